bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning binary input width, legal range 4..16.
REQ-002 SHALL have parameter DIGITS, default 3, meaning number of decimal digits produced, legal range 1..5.
REQ-003 SHALL have parameter BLANK_LZ, default 1, meaning 1 = blank leading-zero digits and 0 = show all digits.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port resetn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request a conversion of bin.
REQ-008 SHALL have port bin, input, WIDTH bits: unsigned value, sampled only when start is accepted.
REQ-009 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when results update.
REQ-011 SHALL have port bcd, output, 4*DIGITS bits: digit i at bits [4i+3:4i], digit 0 = ones.
REQ-012 SHALL have port seg, output, 7*DIGITS bits: active-low gfedcba for digit i at bits [7i+6:7i].
REQ-013 SHALL have port ovf, output, 1 bit: the last accepted bin exceeded 10^DIGITS-1.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-015 SHALL accept start only in IDLE or DONE, capture bin, clear the BCD accumulator, load shift count WIDTH and go to SHIFT.
REQ-016 SHALL ignore start while in SHIFT, with no effect on the conversion or on captured data.
REQ-017 SHALL, in each SHIFT cycle, add 3 to every accumulator digit >= 5 and then shift {accumulator, captured bin} left by 1.
REQ-018 SHALL move from SHIFT to DONE after exactly WIDTH shift cycles.
REQ-019 SHALL, in DONE, hold done=1 for exactly one cycle and then return to IDLE unless start is accepted in that cycle.
REQ-020 SHALL meet this latency: start accepted at edge k gives busy=1 for cycles k+1..k+WIDTH, then done=1 with bcd/seg/ovf valid at cycle k+WIDTH+1.
REQ-021 SHALL update bcd, seg and ovf only on entry to DONE, and hold them stable otherwise.
REQ-022 SHALL set ovf=1 if captured bin > 10^DIGITS-1; bcd then holds bin mod 10^DIGITS, with carries out of the top digit discarded.
REQ-023 SHALL use segment codes 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, and 1111111 (blank) for codes 10..15.
REQ-024 SHALL, when BLANK_LZ=1, drive 1111111 for every zero digit above the most significant non-zero digit; digit 0 is never blanked.
REQ-025 SHALL, when BLANK_LZ=0, never blank any digit.
REQ-026 SHALL register seg, with no combinational path from bin or start to any output.

Reset
REQ-027 SHALL, with resetn=0 at a clock edge, force IDLE, busy=0, done=0, bcd=0, ovf=0 and every seg digit = 1111111.
REQ-028 SHALL, when reset is asserted mid-SHIFT, abandon the conversion with no done pulse; start sampled in the same cycle as resetn=0 is ignored.

Structure
REQ-029 SHALL take the segment code constants and FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) from the shared seg7_defs package/include file.
REQ-030 SHALL instantiate one combinational sub-module, bcd_to_seg7 (4-bit code in, 7-bit active-low segments out), once per digit via generate.
REQ-031 SHALL size the shift counter at clog2(WIDTH+1) bits.

Verification
REQ-032 Bench SHALL cover: WIDTH=8, DIGITS=3, bin=255, start one cycle -> busy for 8 cycles, done at cycle 9, bcd=12'h255, seg digits 2/5/5, ovf=0.
REQ-033 Bench SHALL cover: bin=0, BLANK_LZ=1 -> bcd=12'h000, seg[6:0]=1000000, upper two digits 1111111; same with BLANK_LZ=0 -> all three digits 1000000.
REQ-034 Bench SHALL cover: start with bin=7, then start with bin=200 on cycle 3 while busy -> single done, bcd=12'h007, seg digit 0 = 1111000.
REQ-035 Bench SHALL cover: WIDTH=8, DIGITS=2, bin=150 -> ovf=1, bcd=8'h50, seg digits 5/0.
REQ-036 Bench SHALL cover: resetn=0 for one cycle at shift cycle 4 of bin=99 -> no done, outputs at reset values, next start with bin=42 -> bcd=12'h042.
REQ-037 Bench SHALL cover: start asserted in the done cycle with bin=13 -> accepted, busy next cycle, next done after 9 cycles with bcd=12'h013.

Source files
------------

// File: rtl/seg7_defs.sv
// Shared definitions for the binary-to-BCD converter: FSM state encoding
// and active-low gfedcba seven-segment codes.
package seg7_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational decoder: one BCD code to active-low gfedcba segments.
// Codes 10..15 are not decimal digits and show as blank.
module bcd_to_seg7
  import seg7_defs::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Look up the segment pattern for the incoming code
  always_comb begin
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with registered
// seven-segment outputs and optional leading-zero blanking.
// One bit is shifted in per cycle; results appear together with a
// one-cycle done pulse and are held until the next conversion ends.
module bin_to_bcd_seq
  import seg7_defs::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  ovf
);

  localparam int          ACC_W   = 4 * DIGITS;
  localparam int          SEG_W   = 7 * DIGITS;
  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d, adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_cap_q;
  logic               busy_q, done_q, ovf_q;
  logic [ACC_W-1:0]   bcd_q;
  logic [SEG_W-1:0]   seg_q, seg_raw, seg_d;
  logic               lz;

  // One double-dabble step: bias digits >= 5 by 3, then shift the next
  // binary bit in. The carry out of the top digit is dropped, which leaves
  // the accumulator holding the value modulo 10^DIGITS.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    acc_d = ACC_W'({adj, bin_q[WIDTH-1]});
    bin_d = {bin_q[WIDTH-2:0], 1'b0};
  end

  // Segment decoders run on the post-step accumulator so the pattern can be
  // registered on the same edge that enters DONE.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_seg7 u_dec (
      .code_i (acc_d[4*g +: 4]),
      .seg_o  (seg_raw[7*g +: 7])
    );
  end

  // Blank zero digits above the most significant non-zero one; ones digit stays lit
  always_comb begin
    seg_d = seg_raw;
    lz    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (acc_d[4*i +: 4] != 4'd0) lz = 1'b0;
      if ((BLANK_LZ != 0) && lz && (i != 0)) seg_d[7*i +: 7] = SEG_BLANK;
    end
  end

  // Control FSM; published results change only on the edge entering DONE
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q     <= bin;
            acc_q     <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            ovf_cap_q <= (32'(bin) > MAX_VAL);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            state_q   <= IDLE;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= acc_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_cap_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq. Three instances share one input stream:
// DIGITS=3 with blanking, DIGITS=3 without blanking, DIGITS=2 with blanking.
// Accepted conversions are queued by a timing model; a monitor pops the
// queue on every done pulse and derives expected digits arithmetically.
module tb_bin_to_bcd_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic resetn, start;
  logic [W-1:0] bin;

  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [20:0] seg_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_b;
  logic [20:0] seg_b;
  logic        busy_c, done_c, ovf_c;
  logic [7:0]  bcd_c;
  logic [13:0] seg_c;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .seg(seg_a), .ovf(ovf_a));
  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(0)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .seg(seg_b), .ovf(ovf_b));
  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(2), .BLANK_LZ(1)) dut_c (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .seg(seg_c), .ovf(ovf_c));

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
  int ndig [3] = '{3, 3, 2};
  bit blz  [3] = '{1'b1, 1'b0, 1'b1};

  int          exp_q [$];
  int          rem      = 0;
  bit          exp_busy = 1'b0;
  bit          exp_done = 1'b0;
  bit          mon_en   = 1'b0;
  logic [19:0] cur_bcd [3];
  logic [34:0] cur_seg [3];
  logic        cur_ovf [3];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decimal expectation from plain arithmetic on the accepted value
  function automatic void ref_model(input int v, input int nd, input bit bl,
                                    output logic [19:0] b, output logic [34:0] s,
                                    output logic o);
    int m, n, msd;
    int dig [5];
    m = 1;
    for (int i = 0; i < nd; i++) m = m * 10;
    o = (v > m - 1);
    n = v % m;
    b = '0;
    s = '0;
    msd = 0;
    for (int i = 0; i < nd; i++) begin
      dig[i] = n % 10;
      n = n / 10;
      b[4*i +: 4] = 4'(dig[i]);
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < nd; i++)
      s[7*i +: 7] = (bl && i > msd) ? 7'b1111111 : segtab[dig[i]];
  endfunction

  function automatic logic [34:0] blank_all(input int nd);
    logic [34:0] s;
    s = '0;
    for (int i = 0; i < nd; i++) s[7*i +: 7] = 7'b1111111;
    return s;
  endfunction

  task automatic set_reset_expect();
    for (int d = 0; d < 3; d++) begin
      cur_bcd[d] = '0;
      cur_seg[d] = blank_all(ndig[d]);
      cur_ovf[d] = 1'b0;
    end
  endtask

  // Timing model: a conversion occupies W busy cycles, then one done cycle
  always @(posedge clk) begin
    if (!resetn) begin
      if (rem > 0) void'(exp_q.pop_back());
      rem      = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      set_reset_expect();
    end else if (rem > 0) begin
      rem      = rem - 1;
      exp_busy = (rem > 0);
      exp_done = (rem == 0);
    end else begin
      exp_done = 1'b0;
      if (start) begin
        exp_q.push_back(int'(bin));
        rem      = W;
        exp_busy = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
    end
  end

  // Monitor: pop on each done and compare all outputs every cycle
  always @(negedge clk) begin
    logic [19:0] ab [3];
    logic [34:0] as [3];
    logic        ao [3], abz [3], adn [3];
    int          v;
    if (mon_en) begin
      ab[0] = 20'(bcd_a); as[0] = 35'(seg_a); ao[0] = ovf_a; abz[0] = busy_a; adn[0] = done_a;
      ab[1] = 20'(bcd_b); as[1] = 35'(seg_b); ao[1] = ovf_b; abz[1] = busy_b; adn[1] = done_b;
      ab[2] = 20'(bcd_c); as[2] = 35'(seg_c); ao[2] = ovf_c; abz[2] = busy_c; adn[2] = done_c;
      if (done_a) begin
        if (exp_q.size() == 0) begin
          check("done_without_request", 64'(done_a), 64'(0));
        end else begin
          v = exp_q.pop_front();
          for (int d = 0; d < 3; d++)
            ref_model(v, ndig[d], blz[d], cur_bcd[d], cur_seg[d], cur_ovf[d]);
        end
      end
      for (int d = 0; d < 3; d++) begin
        check($sformatf("busy[%0d]", d), 64'(abz[d]), 64'(exp_busy));
        check($sformatf("done[%0d]", d), 64'(adn[d]), 64'(exp_done));
        check($sformatf("bcd[%0d]", d),  64'(ab[d]),  64'(cur_bcd[d]));
        check($sformatf("seg[%0d]", d),  64'(as[d]),  64'(cur_seg[d]));
        check($sformatf("ovf[%0d]", d),  64'(ao[d]),  64'(cur_ovf[d]));
      end
    end
  end

  task automatic issue(input int v);
    @(negedge clk);
    start = 1'b1;
    bin   = W'(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  int picks [6] = '{0, 9, 10, 99, 100, 255};

  initial begin
    bit found;
    set_reset_expect();
    resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Full-scale value, zero, and overflow for the two-digit instance
    issue(255); settle();
    issue(0);   settle();
    issue(150); settle();

    // Start while busy must be ignored
    issue(7);
    @(negedge clk);
    start = 1'b1; bin = 8'd200;
    @(negedge clk);
    start = 1'b0;
    settle();

    // Reset in the middle of a conversion, with start held during reset
    issue(99);
    repeat (3) @(negedge clk);
    resetn = 1'b0; start = 1'b1; bin = 8'd5;
    @(negedge clk);
    resetn = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    issue(42); settle();

    // Start presented during the done cycle is accepted
    issue(64);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done_a) found = 1'b1;
    end
    check("wait_done", 64'(found), 64'(1));
    start = 1'b1; bin = 8'd13;
    @(negedge clk);
    start = 1'b0;
    settle();

    // Random traffic with occasional resets and biased boundary values
    for (int i = 0; i < 2000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      start  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) bin = W'(picks[$urandom_range(0, 5)]);
      else                           bin = W'($urandom_range(0, 255));
      @(negedge clk);
    end
    resetn = 1'b1;
    start  = 1'b0;
    repeat (15) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
